bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//   Two-master arbiter for the shared SoC peripheral bus (RAM, GPIO, PWM decode).
//   Master 0 is the CPU data port; master 1 is a DMA/debug master. Grants are
//   registered, with round-robin tie-break, a burst limit and an optional lock.
//   The arbiter drives the single bus master interface: bAddr/bWData/bWrite/mem_size
//   out, bRData in. Sits between the masters and the bus address decoder.
// PARAMETERS
//   ADDR_W     32  bus address width
//   DATA_W     32  bus data width
//   MAX_BURST  4   granted transfers before forced handover when the other master waits (>=1)
// PORTS
//   clk         in   1       system clock, rising edge
//   rst         in   1       asynchronous, active-low reset
//   m0_req      in   1       master 0 requests a transfer this cycle
//   m0_lock     in   1       master 0 suppresses burst-limit handover while it owns the bus
//   m0_addr     in   ADDR_W  master 0 address
//   m0_wdata    in   DATA_W  master 0 write data
//   m0_we       in   1       master 0 write enable
//   m0_size     in   2       master 0 access size (00 byte, 01 half, 10 word)
//   m0_gnt      out  1       master 0 owns the bus (registered)
//   m0_ack      out  1       master 0 transfer completes at this clock edge
//   m0_rdata    out  DATA_W  read data returned to master 0
//   m1_*        --   --      identical set for master 1
//   bAddr       out  ADDR_W  bus address
//   bWData      out  DATA_W  bus write data
//   bWrite      out  1       bus write strobe
//   mem_size    out  2       bus access size
//   bRData      in   DATA_W  bus read data (combinational from decoder)
// BEHAVIOUR
//   State: owner in {NONE, M0, M1}; cnt (0..MAX_BURST-1); last (last owner, M0/M1).
//   Reset (rst=0, async): owner=NONE, cnt=0, last=M1; m0_gnt=m1_gnt=0; acks=0;
//     bus outputs all 0. Reset mid-transfer drops grant immediately; no write issued.
//   mX_gnt = (owner==MX). mX_ack = mX_gnt & mX_req (combinational, same cycle).
//   Bus mux: owner MX -> bAddr/bWData/mem_size = mX_*; bWrite = mX_req & mX_we.
//     owner NONE -> bAddr=0, bWData=0, mem_size=0, bWrite=0.
//   mX_rdata = bRData when mX_gnt, else 0.
//   Latency: req asserted in cycle N with owner NONE -> gnt in N+1; first ack in N+1.
//   Next-state at each rising edge:
//     NONE: only one req -> that master; both -> master != last; none -> NONE. cnt=0.
//     MX, mX_req=0: other req -> owner=other, cnt=0; else owner=NONE, cnt=0.
//     MX, mX_req=1 (ack): if cnt==MAX_BURST-1:
//       other req & !mX_lock -> owner=other, cnt=0 (forced handover);
//       else stay MX, cnt=0 (counter wraps, no saturation).
//     otherwise stay MX, cnt=cnt+1.
//     last updates to MX whenever owner leaves MX.
//   Handover is direct (MX -> other) with no idle cycle; no cycle has two grants.
//   mX_gnt and mX_ack never assert for both masters in the same cycle.
//   Master holding req low while granted costs one cycle (grant released next edge).
//   Masters must hold req/addr/wdata/we/size stable until ack; ack with req low impossible.
//   MAX_BURST=1: handover after every transfer while both request (strict alternation).
//   Lock held indefinitely starves the other master; this is permitted by design.
// TESTING
//   Reset: rst=0 with m0_req=1 -> all grants/acks 0, bWrite=0; release -> m0_gnt one cycle later.
//   Single master: m1_req=1, m1_we=1, addr=0x100, wdata=0xA5 -> gnt next cycle, bus shows 0x100/0xA5, bWrite=1, m1_ack=1.
//   Tie from idle after reset: both req same cycle -> m0 granted first (last=M1), m1 after m0 drops req.
//   Burst limit: MAX_BURST=4, both req continuously -> grant pattern M0x4, M1x4, M0x4; exactly one ack per cycle.
//   Lock: m0_lock=1, both req -> m0 keeps grant past 4 transfers; m0_lock=0 -> handover at next cnt wrap.
//   Async reset mid-burst: rst=0 on cycle 2 of m1 burst -> m1_gnt low immediately, bWrite=0, restart at tie rule.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master registered-grant arbiter for the shared peripheral bus.
// Round-robin tie-break, burst-limit handover, and an owner lock that suppresses the limit.
module bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] bAddr,
    output logic [DATA_W-1:0] bWData,
    output logic              bWrite,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] bRData
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    owner_t           owner;
    logic [CNT_W-1:0] cnt;
    logic             last_m1;   // 1: M1 was the last owner, so M0 wins the next tie

    // NOTE: owner, burst count and tie-break history are all state; they are
    // updated only with non-blocking assignments so every branch sees the
    // values from before this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner   <= OWN_NONE;
            cnt     <= '0;
            last_m1 <= 1'b1;
        end else begin
            case (owner)
                OWN_NONE: begin
                    cnt <= '0;
                    if (m0_req && m1_req) owner <= last_m1 ? OWN_M0 : OWN_M1;
                    else if (m0_req)      owner <= OWN_M0;
                    else if (m1_req)      owner <= OWN_M1;
                end
                OWN_M0: begin
                    if (!m0_req) begin
                        cnt     <= '0;
                        last_m1 <= 1'b0;
                        owner   <= m1_req ? OWN_M1 : OWN_NONE;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (m1_req && !m0_lock) begin
                            owner   <= OWN_M1;
                            last_m1 <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OWN_M1: begin
                    if (!m1_req) begin
                        cnt     <= '0;
                        last_m1 <= 1'b1;
                        owner   <= m0_req ? OWN_M0 : OWN_NONE;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (m0_req && !m1_lock) begin
                            owner   <= OWN_M0;
                            last_m1 <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    owner <= OWN_NONE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Grants decode straight from the owner register; acks are same-cycle.
    assign m0_gnt = (owner == OWN_M0);
    assign m1_gnt = (owner == OWN_M1);
    assign m0_ack = m0_gnt & m0_req;
    assign m1_ack = m1_gnt & m1_req;

    assign m0_rdata = m0_gnt ? bRData : '0;
    assign m1_rdata = m1_gnt ? bRData : '0;

    always_comb begin
        bAddr    = '0;
        bWData   = '0;
        bWrite   = 1'b0;
        mem_size = 2'b00;
        if (m0_gnt) begin
            bAddr    = m0_addr;
            bWData   = m0_wdata;
            bWrite   = m0_req & m0_we;
            mem_size = m0_size;
        end else if (m1_gnt) begin
            bAddr    = m1_addr;
            bWData   = m1_wdata;
            bWrite   = m1_req & m1_we;
            mem_size = m1_size;
        end
    end

endmodule
